// File: rtl/vending_machine_multi_if.sv
// Signal bundle between the coin/keypad front end, vending_machine_multi and the dispenser/hopper drivers.
interface vending_machine_multi_if #(
   parameter int IDX_W    = 2,
   parameter int CREDIT_W = 8
);
   logic [1:0]          in;
   logic                sel_valid;
   logic [IDX_W-1:0]    sel_id;
   logic                cancel;
   logic                restock;
   logic                out;
   logic [IDX_W-1:0]    vend_id;
   logic                change_valid;
   logic [1:0]          change;
   logic [CREDIT_W-1:0] credit;
   logic                coin_reject;
   logic                sold_out;
   logic                busy;

   modport master (
      output in, sel_valid, sel_id, cancel, restock,
      input  out, vend_id, change_valid, change, credit, coin_reject, sold_out, busy
   );

   modport slave (
      input  in, sel_valid, sel_id, cancel, restock,
      output out, vend_id, change_valid, change, credit, coin_reject, sold_out, busy
   );
endinterface

// File: rtl/vending_machine_multi.sv
// Multi-product vending controller: coin credit, per-item stock, vend pulse and largest-first change.
// Optional idle-refund timeout enabled by defining VEND_TIMEOUT_EN.
module vending_machine_multi #(
   parameter int NUM_ITEMS      = 4,
   parameter int CREDIT_W       = 8,
   parameter int COIN1_VAL      = 5,
   parameter int COIN2_VAL      = 10,
   parameter int COIN3_VAL      = 25,
   parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES = {8'd40, 8'd25, 8'd20, 8'd15},
   parameter int STOCK_W        = 4,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input logic clk,
   input logic rst,
   vending_machine_multi_if.slave bus
);
   localparam int IDX_W = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;
   localparam logic [STOCK_W-1:0]  STOCK_FULL = '1;
   localparam logic [CREDIT_W-1:0] C1 = CREDIT_W'(COIN1_VAL);
   localparam logic [CREDIT_W-1:0] C2 = CREDIT_W'(COIN2_VAL);
   localparam logic [CREDIT_W-1:0] C3 = CREDIT_W'(COIN3_VAL);
   localparam logic [IDX_W:0]      ITEMS = (IDX_W+1)'(NUM_ITEMS);

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_t;

   state_t              state, state_n;
   logic [CREDIT_W-1:0] credit_q, credit_n;
   logic [STOCK_W-1:0]  stock_q [NUM_ITEMS];
   logic [STOCK_W-1:0]  stock_n [NUM_ITEMS];
   logic [CREDIT_W-1:0] price_tab [NUM_ITEMS];
   logic [CREDIT_W-1:0] coin_val, sel_price;
   logic [CREDIT_W:0]   coin_sum;
   logic [STOCK_W-1:0]  sel_stock;
   logic                coin_present, id_ok, accept_cancel, accept_sel;
   logic                out_n, change_valid_n, coin_reject_n, sold_out_n, busy_n;
   logic [IDX_W-1:0]    vend_id_n;
   logic [1:0]          change_n;

   for (genvar g = 0; g < NUM_ITEMS; g++) begin : g_price
      assign price_tab[g] = PRICES[g*CREDIT_W +: CREDIT_W];
   end

   always_comb begin
      coin_val = '0;
      case (bus.in)
         2'b01:   coin_val = C1;
         2'b10:   coin_val = C2;
         2'b11:   coin_val = C3;
         default: coin_val = '0;
      endcase
   end

   // One extra bit on the sum exposes credit overflow for the saturation reject.
   assign coin_sum     = {1'b0, credit_q} + {1'b0, coin_val};
   assign coin_present = (bus.in != 2'b00);
   assign id_ok        = ({1'b0, bus.sel_id} < ITEMS);
   assign sel_stock    = stock_q[bus.sel_id];
   assign sel_price    = price_tab[bus.sel_id];
   assign bus.credit   = credit_q;

`ifdef VEND_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0] IDLE_LAST = TO_W'(TIMEOUT_CYCLES - 1);
   logic [TO_W-1:0] idle_cnt, idle_cnt_n;
   logic            activity;
   assign activity = coin_present || bus.sel_valid || bus.cancel;
`endif

   always_comb begin
      state_n        = state;
      credit_n       = credit_q;
      stock_n        = stock_q;
      out_n          = 1'b0;
      vend_id_n      = '0;
      change_valid_n = 1'b0;
      change_n       = '0;
      coin_reject_n  = 1'b0;
      sold_out_n     = 1'b0;
      accept_cancel  = 1'b0;
      accept_sel     = 1'b0;
`ifdef VEND_TIMEOUT_EN
      idle_cnt_n     = '0;
`endif
      if (bus.restock) begin
         for (int unsigned i = 0; i < NUM_ITEMS; i++) stock_n[i] = STOCK_FULL;
      end
      case (state)
         IDLE, CREDIT: begin
            if (!bus.restock && bus.cancel && state == CREDIT) begin
               accept_cancel = 1'b1;
               state_n       = CHANGE;
            end else if (!bus.restock && bus.sel_valid && id_ok) begin
               if (sel_stock == '0) begin
                  sold_out_n = 1'b1;
               end else if (credit_q >= sel_price) begin
                  accept_sel            = 1'b1;
                  state_n               = VEND;
                  out_n                 = 1'b1;
                  vend_id_n             = bus.sel_id;
                  credit_n              = credit_q - sel_price;
                  stock_n[bus.sel_id]   = sel_stock - STOCK_W'(1);
               end
            end
            // Restock still lets a same-cycle coin through; accepted cancel/select do not.
            if (coin_present) begin
               if (accept_cancel || accept_sel || coin_sum[CREDIT_W]) begin
                  coin_reject_n = 1'b1;
               end else begin
                  credit_n = coin_sum[CREDIT_W-1:0];
                  state_n  = CREDIT;
               end
            end
`ifdef VEND_TIMEOUT_EN
            if (state == CREDIT && !activity) begin
               if (idle_cnt == IDLE_LAST) state_n = CHANGE;
               else                       idle_cnt_n = idle_cnt + TO_W'(1);
            end
`endif
         end
         VEND: begin
            coin_reject_n = coin_present;
            state_n       = (credit_q != '0) ? CHANGE : IDLE;
         end
         CHANGE: begin
            coin_reject_n  = coin_present;
            change_valid_n = 1'b1;
            if (credit_q >= C3) begin
               change_n = 2'b11;
               credit_n = credit_q - C3;
            end else if (credit_q >= C2) begin
               change_n = 2'b10;
               credit_n = credit_q - C2;
            end else if (credit_q >= C1) begin
               change_n = 2'b01;
               credit_n = credit_q - C1;
            end else begin
               change_valid_n = 1'b0;
               credit_n       = '0;
            end
            state_n = (credit_n == '0) ? IDLE : CHANGE;
         end
         default: state_n = IDLE;
      endcase
      busy_n = (state_n == VEND) || (state_n == CHANGE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= IDLE;
         credit_q         <= '0;
         for (int unsigned i = 0; i < NUM_ITEMS; i++) stock_q[i] <= STOCK_FULL;
         bus.out          <= 1'b0;
         bus.vend_id      <= '0;
         bus.change_valid <= 1'b0;
         bus.change       <= '0;
         bus.coin_reject  <= 1'b0;
         bus.sold_out     <= 1'b0;
         bus.busy         <= 1'b0;
      end else begin
         state            <= state_n;
         credit_q         <= credit_n;
         stock_q          <= stock_n;
         bus.out          <= out_n;
         bus.vend_id      <= vend_id_n;
         bus.change_valid <= change_valid_n;
         bus.change       <= change_n;
         bus.coin_reject  <= coin_reject_n;
         bus.sold_out     <= sold_out_n;
         bus.busy         <= busy_n;
      end
   end

`ifdef VEND_TIMEOUT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) idle_cnt <= '0;
      else     idle_cnt <= idle_cnt_n;
   end
`endif
endmodule

// File: tb/tb_vending_machine_multi.sv
// Directed plus randomized bench for vending_machine_multi against a queue-based behavioural model.
module tb_vending_machine_multi;
   localparam int NUM_ITEMS  = 4;
   localparam int IDX_W      = 2;
   localparam int CREDIT_W   = 8;
   localparam int CREDIT_MAX = 255;
   localparam int STOCK_FULL = 15;
`ifdef VEND_TIMEOUT_EN
   localparam int TB_TIMEOUT = 8;
`else
   localparam int TB_TIMEOUT = 1000;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   vending_machine_multi_if #(.IDX_W(IDX_W), .CREDIT_W(CREDIT_W)) bus ();

   vending_machine_multi #(
      .NUM_ITEMS(NUM_ITEMS), .CREDIT_W(CREDIT_W),
      .COIN1_VAL(5), .COIN2_VAL(10), .COIN3_VAL(25),
      .PRICES({8'd40, 8'd25, 8'd20, 8'd15}),
      .STOCK_W(4), .TIMEOUT_CYCLES(TB_TIMEOUT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   // Model: credit, stock, and pending hopper work as a pause count plus a coin queue.
   int m_credit;
   int m_stock [NUM_ITEMS];
   int m_pause;
   int m_coins [$];
   int m_idle;
   int e_out, e_vid, e_cv, e_chg, e_rej, e_so, e_busy, e_credit;

   function automatic int price_of(int i);
      case (i)
         0: return 15;
         1: return 20;
         2: return 25;
         default: return 40;
      endcase
   endfunction

   function automatic int coin_value(int code);
      case (code)
         1: return 5;
         2: return 10;
         3: return 25;
         default: return 0;
      endcase
   endfunction

   task automatic refund(input int amount);
      int c = amount;
      m_coins.delete();
      while (c >= 25) begin m_coins.push_back(3); c -= 25; end
      while (c >= 10) begin m_coins.push_back(2); c -= 10; end
      while (c >= 5)  begin m_coins.push_back(1); c -= 5;  end
   endtask

   task automatic model_reset();
      m_credit = 0;
      for (int i = 0; i < NUM_ITEMS; i++) m_stock[i] = STOCK_FULL;
      m_pause = 0;
      m_coins.delete();
      m_idle = 0;
   endtask

   function automatic bit model_busy();
      return (m_pause > 0) || (m_coins.size() > 0);
   endfunction

   task automatic model_step(input int coin, input bit sv, input int sid, input bit cn, input bit rs);
      bit busy = model_busy();
      bit accepted = 1'b0;
      bit fire = 1'b0;
      e_out = 0; e_vid = 0; e_cv = 0; e_chg = 0; e_rej = 0; e_so = 0;
`ifdef VEND_TIMEOUT_EN
      if (!busy && m_credit > 0 && coin == 0 && !sv && !cn) begin
         m_idle++;
         if (m_idle == TB_TIMEOUT) begin fire = 1'b1; m_idle = 0; end
      end else begin
         m_idle = 0;
      end
`endif
      if (rs) for (int i = 0; i < NUM_ITEMS; i++) m_stock[i] = STOCK_FULL;
      if (busy) begin
         if (coin != 0) e_rej = 1;
         if (m_pause > 0) begin
            m_pause--;
         end else begin
            e_cv = 1;
            e_chg = m_coins.pop_front();
            m_credit -= coin_value(e_chg);
         end
      end else begin
         if (!rs && cn && m_credit > 0) begin
            refund(m_credit);
            m_pause = 0;
            accepted = 1'b1;
         end else if (!rs && sv && sid < NUM_ITEMS) begin
            if (m_stock[sid] == 0) begin
               e_so = 1;
            end else if (m_credit >= price_of(sid)) begin
               e_out = 1;
               e_vid = sid;
               m_credit -= price_of(sid);
               m_stock[sid]--;
               m_pause = 1;
               refund(m_credit);
               accepted = 1'b1;
            end
         end
         if (coin != 0) begin
            if (accepted || m_credit + coin_value(coin) > CREDIT_MAX) e_rej = 1;
            else m_credit += coin_value(coin);
         end
         if (fire) begin
            refund(m_credit);
            m_pause = 0;
         end
      end
      e_busy = model_busy() ? 1 : 0;
      e_credit = m_credit;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
      end
   endtask

   task automatic check_outputs();
      chk("out", 32'(bus.out), e_out);
      if (e_out != 0) chk("vend_id", 32'(bus.vend_id), e_vid);
      chk("change_valid", 32'(bus.change_valid), e_cv);
      if (e_cv != 0) chk("change", 32'(bus.change), e_chg);
      chk("coin_reject", 32'(bus.coin_reject), e_rej);
      chk("sold_out", 32'(bus.sold_out), e_so);
      chk("busy", 32'(bus.busy), e_busy);
      chk("credit", 32'(bus.credit), e_credit);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_out"}, 32'(bus.out), 0);
      chk({tag, "_change_valid"}, 32'(bus.change_valid), 0);
      chk({tag, "_coin_reject"}, 32'(bus.coin_reject), 0);
      chk({tag, "_sold_out"}, 32'(bus.sold_out), 0);
      chk({tag, "_busy"}, 32'(bus.busy), 0);
      chk({tag, "_credit"}, 32'(bus.credit), 0);
   endtask

   // Called at a falling edge: drive, let the DUT sample, check just after the rising edge.
   task automatic cycle(input int coin, input bit sv, input int sid, input bit cn, input bit rs);
      bus.in        = 2'(coin);
      bus.sel_valid = sv;
      bus.sel_id    = IDX_W'(sid);
      bus.cancel    = cn;
      bus.restock   = rs;
      model_step(coin, sv, sid, cn, rs);
      @(posedge clk);
      #1;
      cyc++;
      check_outputs();
      @(negedge clk);
   endtask

   task automatic idle();
      cycle(0, 1'b0, 0, 1'b0, 1'b0);
   endtask

   task automatic drain();
      for (int k = 0; k < 64 && model_busy(); k++) idle();
   endtask

   initial begin
      bus.in = 2'b00; bus.sel_valid = 1'b0; bus.sel_id = '0; bus.cancel = 1'b0; bus.restock = 1'b0;
      model_reset();
      #12;
      check_all_zero("reset");
      @(negedge clk);
      rst = 1'b0;

      // Two COIN2 then item 1 (price 20): exact vend, no change.
      cycle(2, 1'b0, 0, 1'b0, 1'b0);
      chk("tp1_credit10", 32'(bus.credit), 10);
      cycle(2, 1'b0, 0, 1'b0, 1'b0);
      chk("tp1_credit20", 32'(bus.credit), 20);
      cycle(0, 1'b1, 1, 1'b0, 1'b0);
      chk("tp1_out", 32'(bus.out), 1);
      chk("tp1_credit0", 32'(bus.credit), 0);
      idle();
      chk("tp1_nochange", 32'(bus.change_valid), 0);

      // 25+25, item 0 (15): change 25 then 10.
      cycle(3, 1'b0, 0, 1'b0, 1'b0);
      cycle(3, 1'b0, 0, 1'b0, 1'b0);
      chk("tp2_credit50", 32'(bus.credit), 50);
      cycle(0, 1'b1, 0, 1'b0, 1'b0);
      idle();
      idle();
      chk("tp2_chg25", 32'(bus.change), 3);
      idle();
      chk("tp2_chg10", 32'(bus.change), 2);
      chk("tp2_idle", 32'(bus.busy), 0);

      // Insufficient credit for item 3, then cancel refunds 10,10.
      cycle(2, 1'b0, 0, 1'b0, 1'b0);
      cycle(2, 1'b0, 0, 1'b0, 1'b0);
      cycle(0, 1'b1, 3, 1'b0, 1'b0);
      chk("tp3_noout", 32'(bus.out), 0);
      chk("tp3_kept", 32'(bus.credit), 20);
      cycle(0, 1'b0, 0, 1'b1, 1'b0);
      drain();

      // Exhaust item 2, sold out, restock, vend again.
      for (int n = 0; n < STOCK_FULL; n++) begin
         cycle(3, 1'b0, 0, 1'b0, 1'b0);
         cycle(0, 1'b1, 2, 1'b0, 1'b0);
         drain();
      end
      cycle(3, 1'b0, 0, 1'b0, 1'b0);
      cycle(0, 1'b1, 2, 1'b0, 1'b0);
      chk("tp4_sold_out", 32'(bus.sold_out), 1);
      chk("tp4_credit_kept", 32'(bus.credit), 25);
      cycle(0, 1'b0, 0, 1'b0, 1'b1);
      cycle(0, 1'b1, 2, 1'b0, 1'b0);
      chk("tp4_restocked_vend", 32'(bus.out), 1);
      drain();

      // Coin during CHANGE and coin alongside an accepted select are rejected.
      cycle(3, 1'b0, 0, 1'b0, 1'b0);
      cycle(3, 1'b0, 0, 1'b0, 1'b0);
      cycle(0, 1'b0, 0, 1'b1, 1'b0);
      cycle(1, 1'b0, 0, 1'b0, 1'b0);
      chk("tp5_reject_change", 32'(bus.coin_reject), 1);
      drain();
      cycle(3, 1'b0, 0, 1'b0, 1'b0);
      cycle(2, 1'b1, 0, 1'b0, 1'b0);
      chk("tp5_reject_sel", 32'(bus.coin_reject), 1);
      chk("tp5_credit", 32'(bus.credit), 10);
      drain();

      // Saturation at 250.
      for (int n = 0; n < 10; n++) cycle(3, 1'b0, 0, 1'b0, 1'b0);
      chk("tp6_credit250", 32'(bus.credit), 250);
      cycle(3, 1'b0, 0, 1'b0, 1'b0);
      chk("tp6_sat_reject", 32'(bus.coin_reject), 1);
      chk("tp6_sat_credit", 32'(bus.credit), 250);

      // Reset in the middle of the refund; stock must return to full.
      cycle(0, 1'b0, 0, 1'b1, 1'b0);
      idle();
      rst = 1'b1;
      #1;
      check_all_zero("midreset");
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      for (int n = 0; n <= STOCK_FULL; n++) begin
         cycle(3, 1'b0, 0, 1'b0, 1'b0);
         cycle(0, 1'b1, 2, 1'b0, 1'b0);
         drain();
      end
      chk("tp7_sold_out_after_full", 32'(bus.sold_out), 1);
      cycle(0, 1'b0, 0, 1'b1, 1'b0);
      drain();

`ifdef VEND_TIMEOUT_EN
      cycle(1, 1'b0, 0, 1'b0, 1'b0);
      for (int n = 0; n < TB_TIMEOUT; n++) idle();
      chk("tp8_timeout_busy", 32'(bus.busy), 1);
      idle();
      chk("tp8_refund_valid", 32'(bus.change_valid), 1);
      chk("tp8_refund_coin", 32'(bus.change), 1);
      drain();
`endif

      for (int n = 0; n < 1500; n++) begin
         int coin = ($urandom_range(0, 99) < 40) ? int'($urandom_range(1, 3)) : 0;
         bit sv   = ($urandom_range(0, 99) < 20);
         int sid  = int'($urandom_range(0, NUM_ITEMS - 1));
         bit cn   = ($urandom_range(0, 99) < 4);
         bit rs   = ($urandom_range(0, 99) < 2);
         cycle(coin, sv, sid, cn, rs);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
